// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: RV32I fetch front end -- PC register, fixed-latency imem requests, DEPTH-entry {instr, pc} FIFO.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky o_misalign and halt fetch.
module rv_fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic             o_dec_valid,
  input  logic             i_dec_ready,
  output logic [WIDTH-1:0] o_dec_instr,
  output logic [WIDTH-1:0] o_dec_pc,
  output logic [WIDTH-1:0] o_dec_pc_plus_4,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic             o_misalign
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_OCC = DEPTH[CW:0];

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WIDTH-1:0] instr_mem_d [DEPTH];
  logic [WIDTH-1:0] pc_mem_q [DEPTH];
  logic [WIDTH-1:0] pc_mem_d [DEPTH];

  logic             halted;
  logic [WIDTH-1:0] redirect_target;
  logic [CW:0]      occupancy;
  logic             imem_req;
  logic             dec_valid;
  logic             deq;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign halted          = misalign_q;
  assign o_misalign      = misalign_q;
  // The fault address is kept unmodified so it shows on o_imem_addr.
  assign redirect_target = i_redirect_pc;
`else
  assign halted          = 1'b0;
  assign o_misalign      = 1'b0;
  assign redirect_target = i_redirect_pc & ~WIDTH'(3);
`endif

  // Decode handshake: the head entry transfers on every cycle with
  // o_dec_valid && i_dec_ready; while valid && !ready the head holds steady.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    // Credit ignores a same-cycle dequeue, so a response always has a free slot.
    imem_req   = !i_rst && !i_redirect && !halted && (occupancy < DEPTH_OCC);
    dec_valid  = (count_q != '0);
    deq        = dec_valid && i_dec_ready;
  end

  always_comb begin
    pc_d        = pc_q;
    inflight_d  = 1'b0;
    req_pc_d    = req_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    if (i_redirect) begin
      // Flush everything, including the response returning this cycle.
      pc_d       = redirect_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_d = |i_redirect_pc[1:0];
`endif
    end else begin
      if (imem_req) begin
        pc_d       = pc_q + WIDTH'(4);
        inflight_d = 1'b1;
        req_pc_d   = pc_q;
      end
      if (inflight_q) begin
        instr_mem_d[wr_ptr_q] = i_imem_rdata;
        pc_mem_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d              = wr_ptr_q + AW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({inflight_q, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      req_pc_q    <= req_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign o_imem_req      = imem_req;
  assign o_imem_addr     = pc_q;
  assign o_dec_valid     = dec_valid;
  assign o_dec_instr     = instr_mem_q[rd_ptr_q];
  assign o_dec_pc        = pc_mem_q[rd_ptr_q];
  assign o_dec_pc_plus_4 = pc_mem_q[rd_ptr_q] + WIDTH'(4);

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_rv_fetch_unit;

  localparam int          TB_DEPTH = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0100;
  localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_dec_valid;
  logic        i_dec_ready = 1'b1;
  logic [31:0] o_dec_instr;
  logic [31:0] o_dec_pc;
  logic [31:0] o_dec_pc_plus_4;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_misalign;

  always #5 clk = ~clk;

  rv_fetch_unit #(.WIDTH(32), .DEPTH(TB_DEPTH), .RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_rdata(i_imem_rdata),
    .o_dec_valid(o_dec_valid), .i_dec_ready(i_dec_ready),
    .o_dec_instr(o_dec_instr), .o_dec_pc(o_dec_pc), .o_dec_pc_plus_4(o_dec_pc_plus_4),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_misalign(o_misalign)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] exp_q[$];        // expected instructions, head first
  logic [31:0] exp_pc_q[$];     // matching PCs
  logic [31:0] m_pc       = RST_PC;
  logic        m_inflight = 1'b0;
  logic [31:0] m_req_pc   = 32'h0;
  logic        m_mis      = 1'b0;
  logic [31:0] mem_next   = 32'h0;

  // observed traffic for directed checks
  logic [31:0] dlog_pc[$];
  logic [31:0] dlog_instr[$];
  logic [31:0] dlog_p4[$];
  int          dlog_cyc[$];
  logic [31:0] rlog_addr[$];
  int          rlog_cyc[$];

  always @(negedge clk) begin
    logic exp_req;
    logic exp_valid;
    exp_req   = !i_rst && !i_redirect && !m_mis && ((exp_q.size() + (m_inflight ? 1 : 0)) < TB_DEPTH);
    exp_valid = (exp_q.size() != 0);
    if (chk_en) begin
      check("imem_req", {31'b0, o_imem_req}, {31'b0, exp_req});
      check("imem_addr", o_imem_addr, m_pc);
      check("dec_valid", {31'b0, o_dec_valid}, {31'b0, exp_valid});
      check("misalign", {31'b0, o_misalign}, {31'b0, m_mis});
      if (exp_valid) begin
        check("dec_instr", o_dec_instr, exp_q[0]);
        check("dec_pc", o_dec_pc, exp_pc_q[0]);
        check("dec_pc_plus_4", o_dec_pc_plus_4, exp_pc_q[0] + 32'd4);
      end
    end
    if (o_dec_valid && i_dec_ready) begin
      dlog_pc.push_back(o_dec_pc);
      dlog_instr.push_back(o_dec_instr);
      dlog_p4.push_back(o_dec_pc_plus_4);
      dlog_cyc.push_back(cyc);
    end
    if (o_imem_req) begin
      rlog_addr.push_back(o_imem_addr);
      rlog_cyc.push_back(cyc);
    end
    // instruction memory: data for a request appears the following cycle
    mem_next = o_imem_req ? (o_imem_addr ^ MEM_KEY) : 32'hDEAD_BEEF;
    // advance the model to the state after the coming edge
    if (i_rst) begin
      exp_q.delete(); exp_pc_q.delete();
      m_pc = RST_PC; m_inflight = 1'b0; m_mis = 1'b0;
    end else if (i_redirect) begin
      exp_q.delete(); exp_pc_q.delete();
      m_inflight = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc  = i_redirect_pc;
      m_mis = (i_redirect_pc % 4) != 0;
`else
      m_pc  = (i_redirect_pc / 4) * 4;
      m_mis = 1'b0;
`endif
    end else begin
      if (exp_valid && i_dec_ready) begin
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
      if (m_inflight) begin
        exp_q.push_back(i_imem_rdata);
        exp_pc_q.push_back(m_req_pc);
      end
      if (exp_req) begin
        m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
    cyc++;
  end

  always begin
    @(posedge clk); #1;
    i_imem_rdata = mem_next;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    dlog_pc.delete(); dlog_instr.delete(); dlog_p4.delete(); dlog_cyc.delete();
    rlog_addr.delete(); rlog_cyc.delete();
  endtask

  function automatic logic [31:0] dpc(input int i);
    return (i < dlog_pc.size()) ? dlog_pc[i] : 32'hDEAD_DEAD;
  endfunction
  function automatic logic [31:0] dcy(input int i);
    return (i < dlog_cyc.size()) ? 32'(dlog_cyc[i]) : 32'hDEAD_DEAD;
  endfunction
  function automatic logic [31:0] raddr(input int i);
    return (i < rlog_addr.size()) ? rlog_addr[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, o_imem_req}, 32'd0);
    check({tag, "_addr"}, o_imem_addr, 32'h0000_0100);
    check({tag, "_valid"}, {31'b0, o_dec_valid}, 32'd0);
    check({tag, "_instr"}, o_dec_instr, 32'h0);
    check({tag, "_pc"}, o_dec_pc, 32'h0);
    check({tag, "_pc4"}, o_dec_pc_plus_4, 32'h4);
    check({tag, "_misalign"}, {31'b0, o_misalign}, 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c0;
    int t;
    int stale;

    // reset values
    tick(3);
    settle();
    check_reset_outputs("rst");
    chk_en = 1'b1;

    // S1: streaming from reset release with decode always ready
    tick(1);
    i_rst = 1'b0; clear_logs(); c0 = cyc;
    tick(6);
    check("s1_pc0", dpc(0), 32'h0000_0100);
    check("s1_pc1", dpc(1), 32'h0000_0104);
    check("s1_pc2", dpc(2), 32'h0000_0108);
    check("s1_instr0", (dlog_instr.size() > 0) ? dlog_instr[0] : 32'hDEAD_DEAD, 32'hA5A5_0100);
    check("s1_first_cycle", dcy(0), 32'(c0 + 2));
    check("s1_back_to_back", dcy(2), 32'(c0 + 4));

    // S2: decode stalled from reset release, then released
    i_rst = 1'b1; tick(2);
    i_rst = 1'b0; i_dec_ready = 1'b0; clear_logs();
    tick(10);
    check("s2_req_count", 32'(rlog_addr.size()), 32'd4);
    check("s2_last_req", raddr(3), 32'h0000_010C);
    settle();
    check("s2_req_low", {31'b0, o_imem_req}, 32'd0);
    check("s2_head_hold", o_dec_pc, 32'h0000_0100);
    tick(1);
    i_dec_ready = 1'b1; clear_logs(); c0 = cyc;
    tick(8);
    check("s2_drain0", dpc(0), 32'h0000_0100);
    check("s2_drain3", dpc(3), 32'h0000_010C);
    check("s2_resume_pc", dpc(4), 32'h0000_0110);
    check("s2_resume_req", raddr(0), 32'h0000_0110);
    check("s2_resume_cycle", (rlog_cyc.size() > 0) ? 32'(rlog_cyc[0]) : 32'hDEAD_DEAD, 32'(c0 + 1));

    // S3: redirect with three entries queued and one response in flight
    i_rst = 1'b1; tick(2);
    i_rst = 1'b0; i_dec_ready = 1'b0;
    tick(4);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_2000; t = cyc;
    tick(1);
    i_redirect = 1'b0; i_dec_ready = 1'b1; clear_logs();
    settle();
    check("s3_valid_after", {31'b0, o_dec_valid}, 32'd0);
    check("s3_addr_after", o_imem_addr, 32'h0000_2000);
    tick(5);
    check("s3_first_pc", dpc(0), 32'h0000_2000);
    check("s3_first_cycle", dcy(0), 32'(t + 3));
    check("s3_second_pc", dpc(1), 32'h0000_2004);
    stale = 0;
    foreach (dlog_pc[i]) if (dlog_pc[i] < 32'h0000_2000) stale++;
    check("s3_no_stale", 32'(stale), 32'd0);

    // S4: redirect to the top of the address space
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    i_redirect = 1'b0; clear_logs();
    tick(5);
    check("s4_pc0", dpc(0), 32'hFFFF_FFFC);
    check("s4_pc1", dpc(1), 32'h0000_0000);
    check("s4_pc4_wrap", (dlog_p4.size() > 0) ? dlog_p4[0] : 32'hDEAD_DEAD, 32'h0000_0000);

    // S5: reset with a loaded FIFO and a request in flight
    i_rst = 1'b1; tick(2);
    i_rst = 1'b0; i_dec_ready = 1'b0;
    tick(5);
    i_rst = 1'b1;
    tick(1);
    settle();
    check_reset_outputs("s5");
    tick(1);
    i_rst = 1'b0; i_dec_ready = 1'b1; clear_logs();
    tick(6);
    check("s5_restart_pc", dpc(0), 32'h0000_0100);
    check("s5_restart_instr", (dlog_instr.size() > 0) ? dlog_instr[0] : 32'hDEAD_DEAD, 32'hA5A5_0100);

    // S6: misaligned redirect
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_1002;
    tick(1);
    i_redirect = 1'b0; clear_logs();
    tick(4);
`ifdef FETCH_ALIGN_CHECK_EN
    check("s6_no_req", 32'(rlog_addr.size()), 32'd0);
    check("s6_misalign", {31'b0, o_misalign}, 32'd1);
    check("s6_fault_addr", o_imem_addr, 32'h0000_1002);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_1004;
    tick(1);
    i_redirect = 1'b0; clear_logs();
    tick(3);
    check("s6_cleared", {31'b0, o_misalign}, 32'd0);
    check("s6_resume", raddr(0), 32'h0000_1004);
`else
    check("s6_aligned_req", raddr(0), 32'h0000_1000);
    check("s6_aligned_pc", dpc(0), 32'h0000_1000);
    check("s6_no_misalign", {31'b0, o_misalign}, 32'd0);
`endif

    tick(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
